// File: rtl/branch_pc_unit.sv
// Program counter and conditional-branch stage: latches ALU flags, resolves branches,
// drives the fetch address and squashes wrong-path instructions after a taken branch.
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        in_valid,
  input  logic        flag_we,
  input  logic [7:0]  status_in,
  input  logic [15:0] alu_out,
  input  logic        br_en,
  input  logic [2:0]  br_cond,
  input  logic        br_indirect,
  input  logic [15:0] br_target,
  output logic [15:0] pc_out,
  output logic [7:0]  flags_out,
  output logic        flush,
  output logic        br_taken
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accepted;
  logic [5:0]         eff_flags;
  logic               cond_true;
  logic               taken;
  logic [15:0]        target;
  logic               unused_status;

  assign unused_status = ^status_in[7:6];

  // Same-cycle flag writes are forwarded into the branch decision.
  assign accepted  = in_valid && !stall && (state == RUN);
  assign eff_flags = flag_we ? status_in[5:0] : flags_out[5:0];
  assign target    = br_indirect ? alu_out : br_target;
  assign taken     = accepted && br_en && cond_true;

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = eff_flags[0];
      3'd2: cond_true = eff_flags[1];
      3'd3: cond_true = eff_flags[2];
      3'd4: cond_true = eff_flags[3];
      3'd5: cond_true = eff_flags[4];
      3'd6: cond_true = eff_flags[5];
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out    <= RESET_PC;
      flags_out <= 8'h00;
      state     <= RUN;
      cnt       <= '0;
      flush     <= 1'b0;
      br_taken  <= 1'b0;
    end else if (stall) begin
      br_taken <= 1'b0;
    end else begin
      br_taken <= taken;
      pc_out   <= taken ? target : pc_out + 16'd1;
      if (accepted && flag_we) begin
        flags_out <= {2'b00, status_in[5:0]};
      end
      case (state)
        RUN: begin
          if (taken) begin
            state <= FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            flush <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus randomized traffic
// against a cycle-level reference model.
module tb_branch_pc_unit;

  localparam logic [15:0] RPC = 16'h0100;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst, stall, in_valid, flag_we, br_en, br_indirect;
  logic [7:0]  status_in;
  logic [15:0] alu_out, br_target;
  logic [2:0]  br_cond;
  logic [15:0] pc_out;
  logic [7:0]  flags_out;
  logic        flush, br_taken;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [7:0]  m_flags;
  int          m_flush_left;
  logic        m_taken;

  branch_pc_unit #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .flag_we(flag_we),
    .status_in(status_in), .alu_out(alu_out), .br_en(br_en), .br_cond(br_cond),
    .br_indirect(br_indirect), .br_target(br_target), .pc_out(pc_out),
    .flags_out(flags_out), .flush(flush), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; in_valid = 0; flag_we = 0; br_en = 0; br_indirect = 0;
    status_in = 8'h00; alu_out = 16'h0000; br_target = 16'h0000; br_cond = 3'd0;
  endtask

  // Advance the model from the current inputs, clock the DUT, compare all outputs.
  task automatic tick(input string tag);
    logic [7:0] eff;
    bit         take;
    take = 0;
    if (rst) begin
      m_pc = RPC; m_flags = 8'h00; m_flush_left = 0; m_taken = 0;
    end else if (stall) begin
      m_taken = 0;
    end else begin
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (in_valid) begin
        eff = flag_we ? status_in : m_flags;
        if (br_en) begin
          if (br_cond == 3'd0)      take = 1;
          else if (br_cond == 3'd7) take = 0;
          else                      take = eff[int'(br_cond) - 1];
        end
        if (flag_we) m_flags = {2'b00, status_in[5:0]};
      end
      m_pc = take ? (br_indirect ? alu_out : br_target) : m_pc + 16'd1;
      if (take) m_flush_left = FC;
      m_taken = take;
    end
    @(posedge clk);
    #1;
    check({tag, ".pc"},    32'(pc_out),    32'(m_pc));
    check({tag, ".flags"}, 32'(flags_out), 32'(m_flags));
    check({tag, ".flush"}, 32'(flush),     32'(m_flush_left > 0));
    check({tag, ".taken"}, 32'(br_taken),  32'(m_taken));
  endtask

  initial begin
    int flush_hi;
    m_pc = RPC; m_flags = 8'h00; m_flush_left = 0; m_taken = 0;
    idle();
    @(negedge clk);

    // Reset for two cycles, then free-running increment
    rst = 1;
    tick("rst0"); tick("rst1");
    check("rst_pc", 32'(pc_out), 32'h0100);
    check("rst_flags", 32'(flags_out), 32'h00);
    check("rst_flush", 32'(flush), 32'h0);
    rst = 0;
    tick("run0");
    check("run_pc0", 32'(pc_out), 32'h0101);
    tick("run1");
    check("run_pc1", 32'(pc_out), 32'h0102);

    // Wrap through 16'hFFFF
    in_valid = 1; br_en = 1; br_cond = 3'd0; br_target = 16'hFFFE;
    tick("wrap_br");
    check("wrap_fffe", 32'(pc_out), 32'hFFFE);
    idle();
    tick("wrap1"); tick("wrap2");
    check("wrap_0000", 32'(pc_out), 32'h0000);
    tick("wrap3");
    check("wrap_0001", 32'(pc_out), 32'h0001);

    // Flag latch with top bits masked, then forwarded EQU branch
    in_valid = 1; flag_we = 1; status_in = 8'hC9;
    tick("flag_latch");
    check("flag_c9", 32'(flags_out), 32'h09);
    status_in = 8'h01; br_en = 1; br_cond = 3'd1; br_target = 16'h0040;
    tick("fwd_br");
    check("fwd_pc", 32'(pc_out), 32'h0040);
    check("fwd_taken", 32'(br_taken), 32'h1);
    idle();
    tick("fwd_post");
    check("fwd_pulse", 32'(br_taken), 32'h0);
    tick("fwd_fl2");

    // Not taken on a cleared flag; never-condition
    in_valid = 1; flag_we = 1; status_in = 8'h02;
    tick("nt_flags");
    flag_we = 0; br_en = 1; br_cond = 3'd1; br_target = 16'h7777;
    tick("nt_equ");
    check("nt_equ_pc", 32'(pc_out), 32'h0044);
    status_in = 8'hFF; flag_we = 1; br_cond = 3'd7;
    tick("nt_never");
    check("nt_never_flush", 32'(flush), 32'h0);

    // Indirect branch, ignored branch during flush, stall extends flush
    idle();
    in_valid = 1; br_en = 1; br_cond = 3'd0; br_indirect = 1; alu_out = 16'h1234;
    tick("ind_br");
    check("ind_pc", 32'(pc_out), 32'h1234);
    flush_hi = 0;
    if (flush) flush_hi++;
    br_indirect = 0; br_target = 16'h5555;
    tick("fl_ign");
    if (flush) flush_hi++;
    idle(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick("fl_stall");
      if (flush) flush_hi++;
    end
    check("stall_pc", 32'(pc_out), 32'h1235);
    stall = 0;
    for (int i = 0; i < 10 && flush; i++) begin
      tick("fl_drain");
      if (flush) flush_hi++;
    end
    check("flush_total", 32'(flush_hi), 32'd5);

    // Reset during the first flush cycle aborts the flush
    in_valid = 1; br_en = 1; br_cond = 3'd0; br_target = 16'h2000;
    tick("rmf_br");
    idle(); rst = 1;
    tick("rmf_rst");
    check("rmf_flush", 32'(flush), 32'h0);
    check("rmf_pc", 32'(pc_out), 32'h0100);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      stall       = ($urandom_range(0, 7) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      flag_we     = ($urandom_range(0, 2) == 0);
      br_en       = ($urandom_range(0, 3) == 0);
      br_indirect = 1'($urandom_range(0, 1));
      br_cond     = 3'($urandom_range(0, 7));
      status_in   = 8'($urandom);
      alu_out     = 16'($urandom);
      br_target   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
